// File: rtl/alu_share_sequencer.sv
// Round-robin sequencer sharing one external ALU between NREQ requesters.
// Optional macro ALU_SEQ_CHAIN_EN adds req_chain: SrcA taken from the previous result.
module alu_share_sequencer #(
   parameter int WIDTH = 32,
   parameter int NREQ  = 2,
   parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NREQ-1:0]       req_valid,
   output logic [NREQ-1:0]       req_ready,
   input  logic [2*NREQ-1:0]     req_op,
   input  logic [WIDTH*NREQ-1:0] req_a,
   input  logic [WIDTH*NREQ-1:0] req_b,
`ifdef ALU_SEQ_CHAIN_EN
   input  logic [NREQ-1:0]       req_chain,
`endif
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [ID_W-1:0]       resp_id,
   output logic [WIDTH-1:0]      resp_result,
   output logic [3:0]            resp_flags,
   output logic [WIDTH-1:0]      alu_src_a,
   output logic [WIDTH-1:0]      alu_src_b,
   output logic [1:0]            alu_ctrl,
   input  logic [WIDTH-1:0]      alu_result,
   input  logic [3:0]            alu_flags,
   output logic                  busy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next_state;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [ID_W-1:0]   r_gnt_id;
   logic [WIDTH-1:0]  r_op_a;
   logic [WIDTH-1:0]  r_op_b;
   logic [1:0]        r_op_ctrl;
   logic [ID_W-1:0]   r_resp_id;
   logic [WIDTH-1:0]  r_resp_result;
   logic [3:0]        r_resp_flags;

   logic              w_grant_found;
   logic [ID_W-1:0]   w_grant_id;
   logic [ID_W-1:0]   w_idx;
   logic              w_hit;
   logic              w_accept;
   logic [WIDTH-1:0]  w_src_a_sel;

   // Round-robin search starting at r_rr_ptr, wrapping modulo NREQ
   always_comb begin
      w_grant_found = 1'b0;
      w_grant_id    = '0;
      w_idx         = '0;
      w_hit         = 1'b0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx         = ID_W'((int'(r_rr_ptr) + k) % NREQ);
         w_hit         = !w_grant_found && req_valid[w_idx];
         w_grant_id    = w_hit ? w_idx : w_grant_id;
         w_grant_found = w_grant_found | w_hit;
      end
   end

   assign w_accept  = (r_state == ST_IDLE) && w_grant_found && !rst;
   assign req_ready = w_accept ? (NREQ'(1) << w_grant_id) : '0;

`ifdef ALU_SEQ_CHAIN_EN
   assign w_src_a_sel = req_chain[w_grant_id] ? r_resp_result
                                              : req_a[WIDTH*w_grant_id +: WIDTH];
`else
   assign w_src_a_sel = req_a[WIDTH*w_grant_id +: WIDTH];
`endif

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_accept) begin
               w_next_state = ST_EXEC;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_EXEC: w_next_state = ST_RESP;
         ST_RESP: begin
            if (resp_ready) begin
               w_next_state = ST_IDLE;
            end else begin
               w_next_state = ST_RESP;
            end
         end
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Operand latch on accept, result capture at the end of EXEC
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rr_ptr      <= '0;
         r_gnt_id      <= '0;
         r_op_a        <= '0;
         r_op_b        <= '0;
         r_op_ctrl     <= 2'b00;
         r_resp_id     <= '0;
         r_resp_result <= '0;
         r_resp_flags  <= 4'b0000;
      end else begin
         if (w_accept) begin
            r_op_a    <= w_src_a_sel;
            r_op_b    <= req_b[WIDTH*w_grant_id +: WIDTH];
            r_op_ctrl <= req_op[2*w_grant_id +: 2];
            r_gnt_id  <= w_grant_id;
            r_rr_ptr  <= (w_grant_id == ID_W'(NREQ-1)) ? '0 : w_grant_id + ID_W'(1);
         end
         if (r_state == ST_EXEC) begin
            r_resp_result <= alu_result;
            r_resp_flags  <= alu_flags;
            r_resp_id     <= r_gnt_id;
         end
      end
   end

   assign alu_src_a   = r_op_a;
   assign alu_src_b   = r_op_b;
   assign alu_ctrl    = r_op_ctrl;
   assign resp_valid  = (r_state == ST_RESP);
   assign resp_id     = r_resp_id;
   assign resp_result = r_resp_result;
   assign resp_flags  = r_resp_flags;
   assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_sequencer.sv
// Directed self-checking bench for alu_share_sequencer with a behavioural ALU.
module tb_alu_share_sequencer;
   localparam int WIDTH = 32;
   localparam int NREQ  = 2;
   localparam int ID_W  = 1;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NREQ-1:0]       req_valid;
   logic [NREQ-1:0]       req_ready;
   logic [1:0]            op0, op1;
   logic [WIDTH-1:0]      a0, a1, b0, b1;
   logic [NREQ-1:0]       req_chain;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [ID_W-1:0]       resp_id;
   logic [WIDTH-1:0]      resp_result;
   logic [3:0]            resp_flags;
   logic [WIDTH-1:0]      alu_src_a, alu_src_b;
   logic [1:0]            alu_ctrl;
   logic [WIDTH-1:0]      alu_result;
   logic [3:0]            alu_flags;
   logic                  busy;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   alu_share_sequencer #(.WIDTH(WIDTH), .NREQ(NREQ)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_op({op1, op0}), .req_a({a1, a0}), .req_b({b1, b0}),
`ifdef ALU_SEQ_CHAIN_EN
      .req_chain(req_chain),
`endif
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
      .resp_result(resp_result), .resp_flags(resp_flags),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl),
      .alu_result(alu_result), .alu_flags(alu_flags), .busy(busy)
   );

   // Behavioural ALU: 00 add, 01 sub, 10 and, 11 or; flags {N,Z,C,V}
   logic [32:0] sum33, dif33;
   logic        c_f, v_f;
   always_comb begin
      sum33 = {1'b0, alu_src_a} + {1'b0, alu_src_b};
      dif33 = {1'b0, alu_src_a} + {1'b0, ~alu_src_b} + 33'd1;
      c_f = 1'b0;
      v_f = 1'b0;
      case (alu_ctrl)
         2'b00: begin
            alu_result = sum33[31:0];
            c_f = sum33[32];
            v_f = (alu_src_a[31] == alu_src_b[31]) && (sum33[31] != alu_src_a[31]);
         end
         2'b01: begin
            alu_result = dif33[31:0];
            c_f = dif33[32];
            v_f = (alu_src_a[31] != alu_src_b[31]) && (dif33[31] != alu_src_a[31]);
         end
         2'b10:   alu_result = alu_src_a & alu_src_b;
         default: alu_result = alu_src_a | alu_src_b;
      endcase
      alu_flags = {alu_result[31], alu_result == 32'd0, c_f, v_f};
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Handshake now, EXEC next cycle, RESP the cycle after, back to IDLE with resp_ready=1
   task automatic do_op(input string tag, input logic [1:0] exp_rdy, input logic exp_id,
                        input logic [31:0] exp_res, input logic [3:0] exp_flg);
      chk({tag, "_ready"}, req_ready, exp_rdy);
      tick();
      chk({tag, "_exec"}, {busy, resp_valid, req_ready}, {1'b1, 1'b0, 2'b00});
      tick();
      chk({tag, "_resp"}, {resp_valid, resp_id, resp_flags, resp_result},
          {1'b1, exp_id, exp_flg, exp_res});
      tick();
      chk({tag, "_idle"}, {busy, resp_valid}, 2'b00);
   endtask

   initial begin
      rst = 1'b1; req_valid = 2'b00; resp_ready = 1'b0; req_chain = 2'b00;
      op0 = 2'b00; op1 = 2'b00; a0 = '0; a1 = '0; b0 = '0; b1 = '0;
      repeat (2) tick();
      chk("reset_outs", {req_ready, resp_valid, resp_id, resp_flags, busy, alu_ctrl}, 11'd0);
      chk("reset_data", {resp_result, alu_src_a}, 64'd0);
      chk("reset_srcb", alu_src_b, 64'd0);

      // Single add on requester 0, explicit latency check
      rst = 1'b0;
      req_valid = 2'b01; op0 = 2'b00; a0 = 32'h5; b0 = 32'h3;
      #1;
      chk("add_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b00;
      chk("add_exec", {busy, resp_valid, req_ready}, {1'b1, 1'b0, 2'b00});
      chk("add_alu_in", {alu_src_a, alu_src_b}, {32'h5, 32'h3});
      tick();
      chk("add_resp", {resp_valid, resp_id, resp_flags, resp_result}, {1'b1, 1'b0, 4'b0000, 32'h8});
      resp_ready = 1'b1;
      tick();
      chk("add_idle", {busy, resp_valid}, 2'b00);

      // Sub on requester 1: negative result, then zero
      req_valid = 2'b10; op1 = 2'b01; a1 = 32'd3; b1 = 32'd5;
      #1;
      do_op("sub_neg", 2'b10, 1'b1, 32'hFFFF_FFFE, 4'b1000);
      a1 = 32'd7; b1 = 32'd7;
      #1;
      do_op("sub_zero", 2'b10, 1'b1, 32'h0, 4'b0110);

      // Round robin with both valid
      req_valid = 2'b11;
      op0 = 2'b00; a0 = 32'd1;    b0 = 32'd1;
      op1 = 2'b11; a1 = 32'hF0;   b1 = 32'h0F;
      #1;
      do_op("rr0", 2'b01, 1'b0, 32'h2, 4'b0000);
      do_op("rr1", 2'b10, 1'b1, 32'hFF, 4'b0000);
      do_op("rr2", 2'b01, 1'b0, 32'h2, 4'b0000);
      do_op("rr3", 2'b10, 1'b1, 32'hFF, 4'b0000);

      // Backpressure in RESP
      resp_ready = 1'b0;
      req_valid = 2'b01; op0 = 2'b10; a0 = 32'hFF00_FF00; b0 = 32'h0FF0_0FF0;
      #1;
      chk("bp_ready", req_ready, 2'b01);
      tick();
      req_valid = 2'b11;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("bp_hold", {resp_valid, req_ready, resp_id, resp_flags, resp_result},
             {1'b1, 2'b00, 1'b0, 4'b0000, 32'h0F00_0F00});
         tick();
      end
      resp_ready = 1'b1;
      tick();
      do_op("bp_next", 2'b10, 1'b1, 32'hFF, 4'b0000);

      // Reset during EXEC discards the operation and clears rr_ptr
      req_valid = 2'b01; op0 = 2'b00; a0 = 32'd9; b0 = 32'd9;
      #1;
      chk("rst_op_ready", req_ready, 2'b01);
      tick();
      rst = 1'b1; req_valid = 2'b00;
      tick();
      chk("rst_mid_outs", {req_ready, resp_valid, resp_id, resp_flags, busy, alu_ctrl}, 11'd0);
      chk("rst_mid_data", {resp_result, alu_src_a}, 64'd0);
      rst = 1'b0;
      tick();
      tick();
      chk("rst_no_resp", {resp_valid, busy}, 2'b00);
      req_valid = 2'b11; a0 = 32'd4; b0 = 32'd6;
      #1;
      do_op("rst_ptr0", 2'b01, 1'b0, 32'd10, 4'b0000);

      // Chained add
      req_valid = 2'b01; op0 = 2'b00; a0 = 32'd2; b0 = 32'd3; req_chain = 2'b00;
      #1;
      do_op("chain_a", 2'b01, 1'b0, 32'd5, 4'b0000);
      a0 = 32'd100; b0 = 32'd10; req_chain = 2'b01;
      #1;
`ifdef ALU_SEQ_CHAIN_EN
      do_op("chain_b", 2'b01, 1'b0, 32'h0000_000F, 4'b0000);
`else
      do_op("chain_b", 2'b01, 1'b0, 32'd110, 4'b0000);
`endif
      req_valid = 2'b00;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
